// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for serial_sub.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out, ovf
   );
   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out, ovf
   );
`else
   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out
   );
   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out
   );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial a - b - borrow_in, LSB first, one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed overflow output.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   serial_sub_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           nxt;
   logic             run;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nx;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d;
   logic             nbr;
   logic             last;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   assign bus.busy = run;
   assign last     = (cnt == CW'(WIDTH - 1));
   assign d        = sa[0] ^ sb[0] ^ br;
   assign nbr      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

   // Result fills from the MSB end so it is aligned after WIDTH shifts.
   always_comb begin
      res_nx            = res >> 1;
      res_nx[WIDTH-1]   = d;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      run = 1'b0;
      unique case (state)
         IDLE: if (bus.start) nxt = RUN;
         RUN: begin
            run = 1'b1;
            if (last) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa             <= '0;
         sb             <= '0;
         res            <= '0;
         cnt            <= '0;
         br             <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff       <= '0;
         bus.borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb          <= 1'b0;
         b_msb          <= 1'b0;
         bus.ovf        <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE && bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            br  <= bus.borrow_in;
            cnt <= '0;
            res <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
`endif
         end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= nbr;
            res <= res_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
               bus.diff       <= res_nx;
               bus.borrow_out <= nbr;
               bus.done       <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
               bus.ovf <= (a_msb != b_msb) & (d != a_msb);
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_sub.sv
// Directed checks of serial_sub at WIDTH 1, 8 and 32.
// Overflow checks compile in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   serial_sub_if #(.WIDTH(1))  i1 ();
   serial_sub_if #(.WIDTH(8))  i8 ();
   serial_sub_if #(.WIDTH(32)) i32 ();

   serial_sub #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(i1));
   serial_sub #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
   serial_sub #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

   int n_chk  = 0;
   int n_fail = 0;
   int wsel   = 8;

   logic        s_busy;
   logic        s_done;
   logic [31:0] s_diff;
   logic        s_bo;

   always_comb begin
      s_busy = i8.busy;
      s_done = i8.done;
      s_diff = 32'(i8.diff);
      s_bo   = i8.borrow_out;
      case (wsel)
         1: begin
            s_busy = i1.busy;
            s_done = i1.done;
            s_diff = 32'(i1.diff);
            s_bo   = i1.borrow_out;
         end
         32: begin
            s_busy = i32.busy;
            s_done = i32.done;
            s_diff = i32.diff;
            s_bo   = i32.borrow_out;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int w, input logic [31:0] a,
                        input logic [31:0] b, input logic bin,
                        input logic st);
      case (w)
         1: begin
            i1.start = st; i1.a = a[0]; i1.b = b[0];
            i1.borrow_in = bin;
         end
         32: begin
            i32.start = st; i32.a = a; i32.b = b;
            i32.borrow_in = bin;
         end
         default: begin
            i8.start = st; i8.a = a[7:0]; i8.b = b[7:0];
            i8.borrow_in = bin;
         end
      endcase
   endtask

   // One full operation; inputs are scrambled after the start edge.
   task automatic run(input int w, input logic [31:0] a,
                      input logic [31:0] b, input logic bin,
                      input logic [31:0] exp_d, input logic exp_bo,
                      input string tag);
      int nb;
      bit seen;
      wsel = w;
      @(negedge clk);
      drive(w, a, b, bin, 1'b1);
      @(negedge clk);
      drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
      nb   = 0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (s_done) seen = 1;
         else begin
            if (s_busy) nb++;
            @(negedge clk);
         end
      end
      chk({tag, "_done"}, 64'(seen), 64'd1);
      chk({tag, "_busy_cycles"}, 64'(nb), 64'(w));
      chk({tag, "_diff"}, 64'(s_diff), 64'(exp_d));
      chk({tag, "_bo"}, 64'(s_bo), 64'(exp_bo));
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(s_done), 64'd0);
      chk({tag, "_hold"}, 64'(s_diff), 64'(exp_d));
   endtask

   initial begin
      int nd;
      logic [31:0] ra, rb, mask;
      logic        rbin;
      logic [32:0] full;
      int          wl[3];
      wl = '{1, 8, 32};
      drive(1, 0, 0, 0, 0);
      drive(8, 0, 0, 0, 0);
      drive(32, 0, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(i8.busy), 64'd0);
      chk("rst_done", 64'(i8.done), 64'd0);
      chk("rst_diff", 64'(i8.diff), 64'd0);
      chk("rst_bo", 64'(i8.borrow_out), 64'd0);
      chk("rst_diff32", 64'(i32.diff), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", 64'(i8.ovf), 64'd0);
`endif
      rst = 1'b0;

      run(8, 32'h5A, 32'h3C, 1'b0, 32'h1E, 1'b0, "w8_5a_3c");
      run(8, 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1, "w8_00_01");
      run(8, 32'h10, 32'h0F, 1'b1, 32'h00, 1'b0, "w8_10_0f_b");
      run(8, 32'h01, 32'h01, 1'b1, 32'hFF, 1'b1, "w8_01_01_b");
`ifdef SERIAL_SUB_OVF_EN
      run(8, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b0, "w8_80_01");
      chk("ovf_80_01", 64'(i8.ovf), 64'd1);
      run(8, 32'h05, 32'h03, 1'b0, 32'h02, 1'b0, "w8_05_03");
      chk("ovf_05_03", 64'(i8.ovf), 64'd0);
`endif

      // Start while busy is ignored; start in the done cycle is taken.
      wsel = 8;
      @(negedge clk);
      drive(8, 32'h20, 32'h10, 1'b0, 1'b1);
      @(negedge clk);
      drive(8, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      drive(8, 32'hFF, 32'h00, 1'b0, 1'b1);
      @(negedge clk);
      drive(8, 0, 0, 0, 0);
      chk("ign_busy", 64'(i8.busy), 64'd1);
      nd = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nd += int'(i8.done);
      end
      chk("ign_early_done", 64'(nd), 64'd0);
      @(negedge clk);
      chk("ign_done", 64'(i8.done), 64'd1);
      chk("ign_diff", 64'(i8.diff), 64'h10);
      drive(8, 32'h09, 32'h02, 1'b0, 1'b1);
      @(negedge clk);
      drive(8, 0, 0, 0, 0);
      chk("b2b_busy", 64'(i8.busy), 64'd1);
      chk("b2b_done_low", 64'(i8.done), 64'd0);
      chk("b2b_hold", 64'(i8.diff), 64'h10);
      nd = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         nd += int'(i8.done);
      end
      chk("b2b_early_done", 64'(nd), 64'd0);
      @(negedge clk);
      chk("b2b_done", 64'(i8.done), 64'd1);
      chk("b2b_diff", 64'(i8.diff), 64'h07);

      // Reset mid-operation aborts with no done pulse.
      @(negedge clk);
      drive(8, 32'h33, 32'h11, 1'b0, 1'b1);
      @(negedge clk);
      drive(8, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(i8.busy), 64'd0);
      chk("abort_diff", 64'(i8.diff), 64'd0);
      chk("abort_done", 64'(i8.done), 64'd0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         nd += int'(i8.done) + int'(i8.busy);
      end
      chk("abort_quiet", 64'(nd), 64'd0);
      run(8, 32'h33, 32'h11, 1'b0, 32'h22, 1'b0, "w8_after_abort");

      run(1, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, "w1_1_0");
      run(1, 32'h0, 32'h1, 1'b0, 32'h1, 1'b1, "w1_0_1");
      run(1, 32'h0, 32'h0, 1'b1, 32'h1, 1'b1, "w1_0_0_b");
      run(1, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0, "w1_1_0_b");
      run(32, 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, "w32_0_1");
      run(32, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0,
          "w32_min_1");
      run(32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0,
          "w32_dead");

      foreach (wl[j]) begin
         mask = (wl[j] == 32) ? 32'hFFFF_FFFF
                              : ((32'd1 << wl[j]) - 32'd1);
         for (int k = 0; k < 4; k++) begin
            ra   = $urandom & mask;
            rb   = $urandom & mask;
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
            run(wl[j], ra, rb, rbin, full[31:0] & mask, full[wl[j]],
                $sformatf("rnd_w%0d_%0d", wl[j], k));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial two's-complement subtractor. It computes `diff = a - b - borrow_in` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the combinational adder cell in the arithmetic library. It serves area-constrained datapaths that can trade latency for a single-bit arithmetic slice.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.

- `clk`  input  1: rising-edge clock, single clock domain.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request to begin a subtraction; sampled only when not busy.
- `a`  input  WIDTH: minuend; captured on the accepted start edge.
- `b`  input  WIDTH: subtrahend; captured on the accepted start edge.
- `borrow_in`  input  1: initial borrow; captured on the accepted start edge.
- `busy`  output  1: high while an operation is in progress.
- `done`  output  1: single-cycle pulse when a result becomes valid.
- `diff`  output  WIDTH: result, held until the next completion.
- `borrow_out`  output  1: final borrow (1 ⇒ unsigned `a < b + borrow_in`), held with `diff`.
- `ovf`  output  1: signed overflow; present only when `SERIAL_SUB_OVF_EN` is defined.

## Operation
- Two-state FSM:
  - IDLE → RUN on `start` = 1.
  - RUN → IDLE when the bit counter reaches WIDTH-1.
- Accepting `start`:
  - Loads `a` and `b` into internal right-shift registers.
  - Loads `borrow_in` into the borrow flop.
  - Clears the bit counter and the internal result shift register.
- Each RUN cycle, with operand LSBs `ai`, `bi` and borrow flop `br`:
  - Result bit `d = ai ^ bi ^ br`, shifted into the result register MSB.
  - Next borrow `br' = (~ai & bi) | (~(ai ^ bi) & br)`.
  - Both operand registers shift right by one.
- Completion edge (last RUN cycle):
  - Final result register value (including that cycle's bit) copies to `diff`.
  - Final `br'` copies to `borrow_out`.
  - `done` = 1 for exactly one cycle; `busy` returns to 0.
- `diff` and `borrow_out` change only on a completion edge. Intermediate shift state is never visible.
- `start` while `busy` = 1 is ignored; there is no queueing.
- `start` during the `done` cycle is accepted, because the FSM is already IDLE. This gives back-to-back operations.
- WIDTH = 1: one RUN cycle; the FSM behaves identically.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow_out` = 0, `ovf` = 0.
  - FSM in IDLE, counter = 0.
- `start` accepted at edge k:
  - `busy` = 1 from after edge k.
  - Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
- At edge k+WIDTH:
  - `diff` and `borrow_out` update.
  - `done` = 1 and `busy` = 0 for the following cycle.
- Latency is WIDTH cycles from the start edge to the result edge. Throughput is one operation per WIDTH+1 cycles.
- Reset mid-operation aborts at the next edge:
  - No `done` pulse is produced.
  - Outputs return to their reset values.
- `a`, `b` and `borrow_in` may change freely after the start edge without affecting the result.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - Operand MSBs are captured at start.
  - At completion, `ovf = (a_msb != b_msb) & (diff_msb != a_msb)`.
  - `ovf` updates together with `diff` and resets to 0.
- Not defined: no `ovf` port and no extra flops; all other behaviour is identical.

## Test plan
- WIDTH = 8, `a` = 0x5A, `b` = 0x3C, `borrow_in` = 0 → exactly 8 cycles later: `done` = 1 for one cycle, `diff` = 0x1E, `borrow_out` = 0, `busy` high for exactly 8 cycles.
- `a` = 0x00, `b` = 0x01, `borrow_in` = 0 → `diff` = 0xFF, `borrow_out` = 1; with `borrow_in` = 1, `a` = 0x10, `b` = 0x0F → `diff` = 0x00, `borrow_out` = 0.
- With `SERIAL_SUB_OVF_EN` defined: `a` = 0x80, `b` = 0x01 → `diff` = 0x7F, `ovf` = 1; `a` = 0x05, `b` = 0x03 → `ovf` = 0.
- Start 0x20-0x10 at edge k; pulse `start` with 0xFF-0x00 at edge k+3 → ignored, single `done` at edge k+8 with `diff` = 0x10; then `start` in the `done` cycle with 0x09-0x02 → `diff` = 0x07 eight cycles later.
- Start 0x33-0x11 at edge k, assert `rst` at edge k+4 → no `done`; `busy` = 0 and `diff` = 0x00 after edge k+4; a new start then completes normally.
- Randomised sweep across WIDTH = 1, 8, 32: `diff`/`borrow_out` match `{borrow_out, diff} = a - b - borrow_in` (mod 2^(WIDTH+1)).
